riscv_pkt_arbiter: RTL
======================

RISCV_PKT_ARBITER -- requirements
Module: riscv_pkt_arbiter

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 512, AXI-Stream tdata width.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, AXI-Stream tuser width.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-004 SHALL have the following ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
- s0_axis_tdata/tkeep/tuser/tvalid/tlast  in  DW/DW/8/UW/1/1  data-path stream from the parser.
- s0_axis_tready  out  1  ready for s0.
- s1_axis_tdata/tkeep/tuser/tvalid/tlast  in  DW/DW/8/UW/1/1  RISC-V core return stream.
- s1_axis_tready  out  1  ready for s1.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  DW/DW/8/UW/1/1  merged egress stream.
- m_axis_tready  in  1  egress back-pressure.
- cfg_rr_en  in  1  1 = round-robin; 0 = strict priority to s1.
- pkt_cnt0, pkt_cnt1  out  32 each  packets accepted from s0 and s1.
- grant_o  out  2  one-hot current grant (bit0 = s0, bit1 = s1); 00 when idle.

Function
REQ-005 SHALL arbitrate at packet granularity: once an input is granted, only that input transfers until its tlast beat is accepted.
REQ-006 SHALL implement the FSM states IDLE, GRANT0 and GRANT1.
REQ-007 In IDLE, no beat transfers; if any sN_axis_tvalid=1, the next state SHALL be the selected GRANTn.
REQ-008 Selection with cfg_rr_en=1: if exactly one input is valid, that input wins; if both are valid, the input other than last_grant wins.
REQ-009 Selection with cfg_rr_en=0: s1 wins whenever s1_axis_tvalid=1, otherwise s0 wins.
REQ-010 cfg_rr_en SHALL be sampled only in IDLE; a change mid-packet does not affect the current grant.
REQ-011 last_grant SHALL update when leaving IDLE.
REQ-012 sN_axis_tready SHALL be (state==GRANTn) && (!m_axis_tvalid || m_axis_tready); it is combinational, and an ungranted input sees tready=0.
REQ-013 An accepted input beat SHALL appear on the m_axis registers the next cycle; latency is exactly 1 cycle and there is no bubble within a packet.
REQ-014 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs SHALL hold stable.
REQ-015 m_axis_tvalid SHALL clear after a handshake when no new beat is accepted in the same cycle.
REQ-016 Acceptance of the granted input's tlast beat SHALL move the FSM to IDLE; this costs one idle cycle per packet, by design.
REQ-017 A single-beat packet (tlast on its first beat) SHALL be handled identically: GRANTn for one accepted beat, then IDLE.
REQ-018 pkt_cntN SHALL increment by 1 on each accepted sN tlast beat, wrapping from 0xFFFFFFFF to 0 with no saturation.
REQ-019 grant_o SHALL reflect the FSM state combinationally.
REQ-020 tkeep and tuser SHALL pass unmodified; the block SHALL NOT inspect tdata.

Reset
REQ-021 While reset=1 at a clk edge, the block SHALL set:
- state to IDLE;
- last_grant to s1, so s0 wins the first tie;
- m_axis_tdata/tkeep/tuser/tlast/tvalid to 0;
- pkt_cnt0 and pkt_cnt1 to 0.
REQ-022 While reset=1, s0_axis_tready and s1_axis_tready SHALL be 0.
REQ-023 A reset asserted mid-packet SHALL abandon the packet; no partial beat is presented after reset releases. Upstream re-framing is the sender's responsibility.

Structure
REQ-024 The state encoding localparams (IDLE=0, GRANT0=1, GRANT1=2) and the counter width (32) SHALL live in the shared package used by the RISC-V datapath blocks.
REQ-025 The block SHALL be a single flat module with no sub-module; the output register is inline.

Verification
REQ-026 Both inputs idle, then s0 sends a 3-beat packet -> beats appear on m_axis 1 cycle after each handshake; grant_o 01→00; pkt_cnt0=1.
REQ-027 With cfg_rr_en=1, s0 and s1 each hold 4-beat packets valid continuously -> egress order is s0, s1, s0, s1; each packet is contiguous; one idle cycle between packets.
REQ-028 With cfg_rr_en=0 and both inputs valid -> every s1 packet is sent first; s0 proceeds only when s1_axis_tvalid=0 in IDLE.
REQ-029 m_axis_tready=0 for 5 cycles mid-packet -> m_axis outputs stable; sN_axis_tready=0; no beat lost or duplicated.
REQ-030 Reset pulsed on beat 2 of a 4-beat s1 packet -> m_axis_tvalid=0 the next cycle; counters 0; the next s0 packet wins the tie against s1.
REQ-031 Preload pkt_cnt1=0xFFFFFFFF via a force, then send one single-beat s1 packet -> pkt_cnt1=0; single-beat transfer correct.

Source files
------------

// File: rtl/riscv_pkt_arbiter_pkg.sv
// Shared definitions for the RISC-V datapath blocks: arbiter state encoding,
// packet-counter width and the input selection rule.
package riscv_pkt_arbiter_pkg;

   localparam int PKT_CNT_W = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT0 = 2'd1;
   localparam logic [1:0] ST_GRANT1 = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      GRANT0 = ST_GRANT0,
      GRANT1 = ST_GRANT1
   } arb_state_t;

   typedef enum logic {
      SRC0 = 1'b0,
      SRC1 = 1'b1
   } src_t;

   // Round-robin only matters on a tie; strict mode always favours the core return path.
   function automatic src_t pick_src(input logic rr_en, input logic v0, input logic v1,
                                     input src_t last);
      src_t pick;
      if (v0 && v1) begin
         if (!rr_en) begin
            pick = SRC1;
         end else if (last == SRC1) begin
            pick = SRC0;
         end else begin
            pick = SRC1;
         end
      end else if (v1) begin
         pick = SRC1;
      end else begin
         pick = SRC0;
      end
      return pick;
   endfunction

endpackage

// File: rtl/riscv_pkt_arbiter.sv
// Two-input AXI-Stream packet arbiter merging the parser data path (s0) and the
// RISC-V core return stream (s1) onto one registered egress stream.
module riscv_pkt_arbiter
   import riscv_pkt_arbiter_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
   input  logic                              clk,
   input  logic                              reset,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
   input  logic                              s0_axis_tvalid,
   input  logic                              s0_axis_tlast,
   output logic                              s0_axis_tready,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
   input  logic                              s1_axis_tvalid,
   input  logic                              s1_axis_tlast,
   output logic                              s1_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,

   input  logic                              cfg_rr_en,
   output logic [PKT_CNT_W-1:0]              pkt_cnt0,
   output logic [PKT_CNT_W-1:0]              pkt_cnt1,
   output logic [1:0]                        grant_o
);

   arb_state_t            state;
   src_t                  last_grant;
   src_t                  pick;
   logic [PKT_CNT_W-1:0]  cnt0_q;
   logic [PKT_CNT_W-1:0]  cnt1_q;

   logic                  out_free;
   logic                  accept0;
   logic                  accept1;
   logic                  accept;
   logic                  sel1;

   logic [C_S_AXIS_DATA_WIDTH-1:0]    sel_tdata;
   logic [C_S_AXIS_DATA_WIDTH/8-1:0]  sel_tkeep;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]   sel_tuser;
   logic                              sel_tlast;

   // The output register can take a beat when it is empty or draining this cycle.
   assign out_free       = !m_axis_tvalid || m_axis_tready;
   // NOTE: reset is synchronous, so state may still read GRANTn during the reset
   // cycle; gating with reset keeps upstream from seeing a handshake that is lost.
   assign s0_axis_tready = !reset && (state == GRANT0) && out_free;
   assign s1_axis_tready = !reset && (state == GRANT1) && out_free;

   assign accept0 = s0_axis_tvalid && s0_axis_tready;
   assign accept1 = s1_axis_tvalid && s1_axis_tready;
   assign accept  = accept0 || accept1;

   assign sel1      = (state == GRANT1);
   assign sel_tdata = sel1 ? s1_axis_tdata : s0_axis_tdata;
   assign sel_tkeep = sel1 ? s1_axis_tkeep : s0_axis_tkeep;
   assign sel_tuser = sel1 ? s1_axis_tuser : s0_axis_tuser;
   assign sel_tlast = sel1 ? s1_axis_tlast : s0_axis_tlast;

   assign pick = pick_src(cfg_rr_en, s0_axis_tvalid, s1_axis_tvalid, last_grant);

   assign grant_o  = {state == GRANT1, state == GRANT0};
   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;

   // NOTE: all state below uses non-blocking assignment so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         last_grant    <= SRC1;
         cnt0_q        <= '0;
         cnt1_q        <= '0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s0_axis_tvalid || s1_axis_tvalid) begin
                  last_grant <= pick;
                  if (pick == SRC1) begin
                     state <= GRANT1;
                  end else begin
                     state <= GRANT0;
                  end
               end
            end
            GRANT0: begin
               if (accept0 && s0_axis_tlast) begin
                  state  <= IDLE;
                  cnt0_q <= cnt0_q + PKT_CNT_W'(1);
               end
            end
            GRANT1: begin
               if (accept1 && s1_axis_tlast) begin
                  state  <= IDLE;
                  cnt1_q <= cnt1_q + PKT_CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase

         // Egress register: load on accept, otherwise empty out once drained.
         if (accept) begin
            m_axis_tdata  <= sel_tdata;
            m_axis_tkeep  <= sel_tkeep;
            m_axis_tuser  <= sel_tuser;
            m_axis_tlast  <= sel_tlast;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule
